// File: rtl/tpiu_pkg.sv
// Shared constants, state type and byte-extraction helper for the TPIU frame decoder.
package tpiu_pkg;

  localparam int TPIU_FRAME_BYTES = 16;
  localparam int TPIU_AUX_BYTE    = 15;
  localparam int TPIU_ID_W        = 7;

  localparam logic [TPIU_ID_W-1:0] TPIU_NULLID = 7'h00;
  localparam logic [TPIU_ID_W-1:0] TPIU_RSVDID = 7'h7F;

  // Last walked position; position 15 is the aux byte and never walked.
  localparam logic [3:0] TPIU_LAST_POS = 4'(TPIU_FRAME_BYTES - 2);

  typedef enum logic {
    IDLE,
    WALK
  } state_t;

  // Byte n of a frame lives at frame[127-8n -: 8].
  function automatic logic [7:0] frameByte(input logic [127:0] frame, input logic [3:0] idx);
    return frame[(127 - 8 * int'(idx)) -: 8];
  endfunction

endpackage

// File: rtl/tpiu_frame_buf.sv
// Two-slot frame store: a working slot being decoded and a pending slot behind it,
// plus wrapping counters of accepted and dropped frames.
module tpiu_frame_buf
  import tpiu_pkg::*;
(
  input  logic         traceClkin,
  input  logic         rst,
  input  logic         i_capture,
  input  logic [127:0] i_frame,
  input  logic         i_release,
  output logic         o_workValid,
  output logic [127:0] o_workFrame,
  output logic         o_pendValid,
  output logic         o_loadWork,
  output logic [15:0]  o_frameCount,
  output logic [15:0]  o_dropCount
);

  logic         r_workValid;
  logic [127:0] r_workFrame;
  logic         r_pendValid;
  logic [127:0] r_pendFrame;
  logic [15:0]  r_frameCount;
  logic [15:0]  r_dropCount;

  logic w_workFree;
  logic w_pendFree;
  logic w_toWork;
  logic w_toPend;
  logic w_drop;

  // A slot counts as free if it is empty now or is being vacated on this same edge.
  assign w_workFree = !r_workValid || (i_release && !r_pendValid);
  assign w_pendFree = !r_pendValid || i_release;
  assign w_toWork   = i_capture && w_workFree;
  assign w_toPend   = i_capture && !w_workFree && w_pendFree;
  assign w_drop     = i_capture && !w_workFree && !w_pendFree;

  // Working slot: load a fresh capture, promote the pending frame, or empty on release.
  always_ff @(posedge traceClkin or posedge rst) begin
    if (rst) begin
      r_workValid <= 1'b0;
      r_workFrame <= '0;
    end else if (w_toWork) begin
      r_workValid <= 1'b1;
      r_workFrame <= i_frame;
    end else if (i_release) begin
      if (r_pendValid) begin
        r_workValid <= 1'b1;
        r_workFrame <= r_pendFrame;
      end else begin
        r_workValid <= 1'b0;
      end
    end
  end

  // Pending slot: holds the next frame while the working one is still being walked.
  always_ff @(posedge traceClkin or posedge rst) begin
    if (rst) begin
      r_pendValid <= 1'b0;
      r_pendFrame <= '0;
    end else if (w_toPend) begin
      r_pendValid <= 1'b1;
      r_pendFrame <= i_frame;
    end else if (i_release) begin
      r_pendValid <= 1'b0;
    end
  end

  // Accepted and dropped frame counters, both free-running and wrapping.
  always_ff @(posedge traceClkin or posedge rst) begin
    if (rst) begin
      r_frameCount <= '0;
      r_dropCount  <= '0;
    end else begin
      if (w_toWork || w_toPend) r_frameCount <= r_frameCount + 16'd1;
      if (w_drop)               r_dropCount  <= r_dropCount + 16'd1;
    end
  end

  assign o_workValid  = r_workValid;
  assign o_workFrame  = r_workFrame;
  assign o_pendValid  = r_pendValid;
  assign o_loadWork   = w_toWork;
  assign o_frameCount = r_frameCount;
  assign o_dropCount  = r_dropCount;

endmodule

// File: rtl/tpiu_frame_decoder.sv
// Walks each captured TPIU frame position by position, tracking the current source
// ID and emitting data bytes through a single valid/ready output register.
module tpiu_frame_decoder
  import tpiu_pkg::*;
#(
  parameter logic [6:0] NULLID = TPIU_NULLID,
  parameter logic [6:0] RSVDID = TPIU_RSVDID
) (
  input  logic         traceClkin,
  input  logic         rst,
  input  logic         FrAvail,
  input  logic [127:0] Frame,
  output logic         ByteValid,
  input  logic         ByteReady,
  output logic [7:0]   ByteData,
  output logic [6:0]   ByteStream,
  output logic [15:0]  FrameCount,
  output logic [15:0]  DropCount
);

  state_t r_state;
  state_t w_nextState;
  logic [3:0] r_pos;
  logic [3:0] w_nextPos;

  logic       r_prevAvail;
  logic [6:0] r_curId;
  logic [6:0] r_pendId;
  logic       r_pendFlag;
  logic       r_byteValid;
  logic [7:0] r_byteData;
  logic [6:0] r_byteStream;

  logic         w_capture;
  logic         w_workValid;
  logic [127:0] w_workFrame;
  logic         w_pendValid;
  logic         w_loadWork;
  logic         w_release;

  logic [127:0] w_frame;
  logic [3:0]   w_pos;
  logic [7:0]   w_byte;
  logic [7:0]   w_auxByte;
  logic         w_aux;
  logic         w_active;
  logic         w_isOdd;
  logic         w_isId;
  logic         w_suppress;
  logic         w_emit;
  logic         w_outFree;
  logic         w_step;

  assign w_capture = (FrAvail != r_prevAvail);

  tpiu_frame_buf u_buf (
    .traceClkin   (traceClkin),
    .rst          (rst),
    .i_capture    (w_capture),
    .i_frame      (Frame),
    .i_release    (w_release),
    .o_workValid  (w_workValid),
    .o_workFrame  (w_workFrame),
    .o_pendValid  (w_pendValid),
    .o_loadWork   (w_loadWork),
    .o_frameCount (FrameCount),
    .o_dropCount  (DropCount)
  );

  // In IDLE the arriving frame bypasses the store so position 0 is decoded on the capture edge.
  assign w_frame    = (r_state == IDLE) ? Frame : w_workFrame;
  assign w_pos      = (r_state == IDLE) ? 4'd0 : r_pos;
  assign w_active   = (r_state == WALK) ? w_workValid : w_loadWork;
  assign w_byte     = frameByte(w_frame, w_pos);
  assign w_auxByte  = frameByte(w_frame, 4'(TPIU_AUX_BYTE));
  assign w_aux      = w_auxByte[w_pos[3:1]];
  assign w_isOdd    = w_pos[0];
  assign w_isId     = !w_isOdd && w_byte[0];
  assign w_suppress = (r_curId == NULLID) || (r_curId == RSVDID);
  assign w_emit     = !w_isId && !w_suppress;
  assign w_outFree  = !r_byteValid || ByteReady;
  assign w_step     = w_active && (w_outFree || !w_emit);
  assign w_release  = w_step && (r_state == WALK) && (r_pos == TPIU_LAST_POS);

  // Remember the last FrAvail level so any toggle marks a new frame.
  always_ff @(posedge traceClkin or posedge rst) begin
    if (rst) r_prevAvail <= 1'b0;
    else     r_prevAvail <= FrAvail;
  end

  // Walk state and position register.
  always_ff @(posedge traceClkin or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_pos   <= 4'd0;
    end else begin
      r_state <= w_nextState;
      r_pos   <= w_nextPos;
    end
  end

  // Next state: start on a load, advance per step, chain into a waiting frame at the end.
  always_comb begin
    w_nextState = r_state;
    w_nextPos   = r_pos;
    case (r_state)
      IDLE: begin
        if (w_loadWork) begin
          w_nextState = WALK;
          w_nextPos   = w_step ? 4'd1 : 4'd0;
        end
      end
      WALK: begin
        if (w_step) begin
          if (r_pos == TPIU_LAST_POS) begin
            w_nextPos = 4'd0;
            if (!(w_pendValid || w_loadWork)) w_nextState = IDLE;
          end else begin
            w_nextPos = r_pos + 4'd1;
          end
        end
      end
      default: begin
        w_nextState = IDLE;
        w_nextPos   = 4'd0;
      end
    endcase
  end

  // Source ID tracking, including the change deferred past the following odd byte.
  always_ff @(posedge traceClkin or posedge rst) begin
    if (rst) begin
      r_curId    <= '0;
      r_pendId   <= '0;
      r_pendFlag <= 1'b0;
    end else if (w_step) begin
      if (w_isId) begin
        if (!w_aux || (w_pos == TPIU_LAST_POS)) begin
          r_curId <= w_byte[7:1];
        end else begin
          r_pendId   <= w_byte[7:1];
          r_pendFlag <= 1'b1;
        end
      end else if (w_isOdd && r_pendFlag) begin
        r_curId    <= r_pendId;
        r_pendFlag <= 1'b0;
      end
    end
  end

  // Output register: load on an emitting step, clear once the byte is taken.
  always_ff @(posedge traceClkin or posedge rst) begin
    if (rst) begin
      r_byteValid  <= 1'b0;
      r_byteData   <= '0;
      r_byteStream <= '0;
    end else if (w_step && w_emit) begin
      r_byteValid  <= 1'b1;
      r_byteData   <= w_isOdd ? w_byte : {w_byte[7:1], w_aux};
      r_byteStream <= r_curId;
    end else if (ByteReady) begin
      r_byteValid <= 1'b0;
    end
  end

  assign ByteValid  = r_byteValid;
  assign ByteData   = r_byteData;
  assign ByteStream = r_byteStream;

endmodule

// File: tb/tb_tpiu_frame_decoder.sv
// Scoreboard bench for tpiu_frame_decoder: directed frames push hand-computed
// {stream, byte} pairs, a monitor pops and compares on every accepted byte.
module tb_tpiu_frame_decoder;

  logic         traceClkin = 1'b0;
  logic         rst;
  logic         FrAvail;
  logic [127:0] Frame;
  logic         ByteValid;
  logic         ByteReady;
  logic [7:0]   ByteData;
  logic [6:0]   ByteStream;
  logic [15:0]  FrameCount;
  logic [15:0]  DropCount;

  logic [14:0] expQ[$];
  logic [7:0]  fb[16];
  int checks = 0;
  int fails  = 0;

  tpiu_frame_decoder dut (
    .traceClkin (traceClkin),
    .rst        (rst),
    .FrAvail    (FrAvail),
    .Frame      (Frame),
    .ByteValid  (ByteValid),
    .ByteReady  (ByteReady),
    .ByteData   (ByteData),
    .ByteStream (ByteStream),
    .FrameCount (FrameCount),
    .DropCount  (DropCount)
  );

  always #5 traceClkin = ~traceClkin;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] packFrame();
    logic [127:0] f;
    f = '0;
    for (int i = 0; i < 16; i++) f[127 - 8*i -: 8] = fb[i];
    return f;
  endfunction

  task automatic pushByte(input logic [6:0] stream, input logic [7:0] data);
    expQ.push_back({stream, data});
  endtask

  task automatic applyStimulus(input logic [127:0] f);
    @(posedge traceClkin);
    #1;
    Frame   = f;
    FrAvail = ~FrAvail;
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 400) begin
      @(posedge traceClkin);
      n++;
    end
    checkOutput(name, expQ.size(), 0);
    repeat (20) @(posedge traceClkin);
    #1;
  endtask

  // Monitor: every byte the DUT hands over must match the head of the queue.
  always @(negedge traceClkin) begin
    if (rst === 1'b0 && ByteValid === 1'b1 && ByteReady === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL unexpected byte: got stream 0x%0h data 0x%0h, expected none", ByteStream, ByteData);
      end else begin
        checkOutput("byte {stream,data}", {17'd0, ByteStream, ByteData}, {17'd0, expQ.pop_front()});
      end
    end
  end

  // Watchdog so a stuck DUT still ends the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; FrAvail = 1'b0; Frame = '0; ByteReady = 1'b1;
    repeat (3) @(posedge traceClkin);
    #1;
    checkOutput("reset ByteValid",  ByteValid, 0);
    checkOutput("reset ByteData",   ByteData, 0);
    checkOutput("reset ByteStream", ByteStream, 0);
    checkOutput("reset FrameCount", FrameCount, 0);
    checkOutput("reset DropCount",  DropCount, 0);
    @(posedge traceClkin); #1; rst = 1'b0;

    // ID 0x01 then 14 data bytes 0x22..0x3C
    fb[0] = 8'h03;
    for (int k = 1; k <= 14; k++) begin fb[k] = 8'(8'h20 + 2*k); pushByte(7'h01, 8'(8'h20 + 2*k)); end
    fb[15] = 8'h00;
    applyStimulus(packFrame());
    waitDrain("drain frame1");
    checkOutput("FrameCount after 1", FrameCount, 1);
    checkOutput("DropCount after 1", DropCount, 0);

    // Delayed ID change: 0x50 stays on stream 1, then stream 2
    fb[0] = 8'h05; fb[1] = 8'h50; fb[15] = 8'h01;
    for (int k = 2; k <= 14; k++) fb[k] = 8'h60;
    pushByte(7'h01, 8'h50);
    for (int k = 2; k <= 14; k++) pushByte(7'h02, 8'h60);
    applyStimulus(packFrame());
    waitDrain("drain delayed id");

    // Even data byte takes its LSB from the aux byte
    fb[0] = 8'h03; fb[1] = 8'h11; fb[2] = 8'h40; fb[15] = 8'h02;
    for (int k = 3; k <= 14; k++) fb[k] = 8'h20;
    pushByte(7'h01, 8'h11);
    pushByte(7'h01, 8'h41);
    for (int k = 3; k <= 14; k++) pushByte(7'h01, 8'h20);
    applyStimulus(packFrame());
    waitDrain("drain aux lsb");

    // Null ID discards the whole frame, next frame resumes on stream 1
    fb[0] = 8'h01; fb[15] = 8'h00;
    for (int k = 1; k <= 14; k++) fb[k] = 8'h30;
    applyStimulus(packFrame());
    waitDrain("drain null id");
    fb[0] = 8'h03;
    for (int k = 1; k <= 14; k++) begin fb[k] = 8'h32; pushByte(7'h01, 8'h32); end
    applyStimulus(packFrame());
    waitDrain("drain resume");
    checkOutput("FrameCount after 5", FrameCount, 5);

    // Backpressure: A works, B pends, C is dropped
    ByteReady = 1'b0;
    fb[0] = 8'h03; fb[15] = 8'h00;
    for (int k = 1; k <= 14; k++) begin fb[k] = 8'(8'h80 + k); pushByte(7'h01, 8'(8'h80 + k)); end
    applyStimulus(packFrame());
    repeat (15) @(posedge traceClkin);
    for (int k = 1; k <= 14; k++) begin fb[k] = 8'(8'hA0 + k); pushByte(7'h01, 8'(8'hA0 + k)); end
    applyStimulus(packFrame());
    repeat (15) @(posedge traceClkin);
    for (int k = 1; k <= 14; k++) fb[k] = 8'(8'hC0 + k);
    applyStimulus(packFrame());
    repeat (5) @(posedge traceClkin);
    #1;
    checkOutput("FrameCount backpressure", FrameCount, 7);
    checkOutput("DropCount backpressure", DropCount, 1);
    checkOutput("held ByteValid", ByteValid, 1);
    checkOutput("held ByteData", ByteData, 8'h81);
    checkOutput("held ByteStream", ByteStream, 7'h01);
    ByteReady = 1'b1;
    waitDrain("drain backpressure");

    // Reset while walking position 7
    fb[0] = 8'h03;
    for (int k = 1; k <= 14; k++) begin fb[k] = 8'h44; pushByte(7'h01, 8'h44); end
    applyStimulus(packFrame());
    repeat (7) @(posedge traceClkin);
    #1;
    rst = 1'b1;
    FrAvail = 1'b0;
    expQ.delete();
    #1;
    checkOutput("midreset ByteValid",  ByteValid, 0);
    checkOutput("midreset ByteData",   ByteData, 0);
    checkOutput("midreset ByteStream", ByteStream, 0);
    checkOutput("midreset FrameCount", FrameCount, 0);
    checkOutput("midreset DropCount",  DropCount, 0);
    repeat (2) @(posedge traceClkin);
    #1; rst = 1'b0;

    // curId restarts at 0: first two bytes are discarded, then stream 2
    fb[0] = 8'h10; fb[1] = 8'h12; fb[2] = 8'h05; fb[15] = 8'h00;
    for (int k = 3; k <= 14; k++) begin fb[k] = 8'h66; pushByte(7'h02, 8'h66); end
    applyStimulus(packFrame());
    waitDrain("drain after reset");
    checkOutput("FrameCount after reset", FrameCount, 1);
    checkOutput("DropCount after reset", DropCount, 0);

    checkOutput("scoreboard empty", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
